// File: rtl/apb4_spifs_xip.sv
// APB4 read-only window onto a SPI NOR flash, backed by a single prefetch line.
// A miss fetches the whole aligned line in one READ (0x03) or FAST_READ (0x0B) transaction.
module apb4_spifs_xip #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          FAST_READ  = 1'b0,
    parameter logic [31:0] WIN_START  = 32'h3000_0000,
    parameter logic [31:0] WIN_END    = 32'h30FF_FFFF
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    input  logic        flush_i,
    output logic        spi_sck_o,
    output logic        spi_nss_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        busy_o
);

    localparam int unsigned LINE_BITS = LINE_WORDS * 32;
    localparam int unsigned OFS_W     = $clog2(LINE_WORDS * 4);
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TX_W      = 8 + ADDR_WIDTH;
    localparam logic [7:0]  CMD_BYTE  = FAST_READ ? 8'h0B : 8'h03;

    typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

    state_t                 state, state_nxt;
    logic [DIV_W-1:0]       div_cnt;
    logic                   phase_hi;
    logic [9:0]             bit_cnt;
    logic [9:0]             state_len;
    logic [TX_W-1:0]        tx_sr;
    logic [LINE_BITS-1:0]   rx_sr;
    logic [ADDR_WIDTH-1:0]  line_tag;
    logic                   line_valid;
    logic                   flush_pend;

    logic                   access, in_win, rd_ok, err, hit, miss;
    logic                   div_last, bit_state, bit_end, last_bit, gap_first;
    logic [31:0]            offset;
    logic [ADDR_WIDTH-1:0]  req_tag;
    logic [31:0]            line_words [LINE_WORDS];
    logic [31:0]            rd_word;
    logic                   unused_bits;

    assign access  = psel_i & penable_i;
    assign in_win  = (paddr_i >= WIN_START) && (paddr_i <= WIN_END);
    assign rd_ok   = access & ~pwrite_i & in_win;
    assign err     = access & (pwrite_i | ~in_win);
    assign offset  = paddr_i - WIN_START;
    assign req_tag = {offset[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
    assign hit     = rd_ok & line_valid & (line_tag == req_tag) & (state == IDLE);
    assign miss    = rd_ok & ~hit & (state == IDLE);

    assign unused_bits = ^{pwdata_i, offset};

    assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_state = state inside {CMD, ADDR, DUMMY, DATA};
    assign bit_end   = bit_state & phase_hi & div_last;
    assign last_bit  = (bit_cnt == state_len - 10'd1);
    assign gap_first = (state == GAP) && (div_cnt == '0);

    always_comb begin
        state_len = 10'd1;
        case (state)
            CMD, DUMMY: state_len = 10'd8;
            ADDR:       state_len = 10'(ADDR_WIDTH);
            DATA:       state_len = 10'(LINE_BITS);
            default:    state_len = 10'd1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = SETUP;
            SETUP:   if (div_last) state_nxt = CMD;
            CMD:     if (bit_end && last_bit) state_nxt = ADDR;
            ADDR:    if (bit_end && last_bit) state_nxt = FAST_READ ? DUMMY : DATA;
            DUMMY:   if (bit_end && last_bit) state_nxt = DATA;
            DATA:    if (bit_end && last_bit) state_nxt = HOLD;
            HOLD:    if (div_last) state_nxt = GAP;
            GAP:     if (div_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase_hi   <= 1'b0;
            bit_cnt    <= '0;
            line_valid <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || div_last) div_cnt <= '0;
            else                                div_cnt <= div_cnt + 1'b1;
            if (!bit_state)    phase_hi <= 1'b0;
            else if (div_last) phase_hi <= ~phase_hi;
            if (state_nxt != state) bit_cnt <= '0;
            else if (bit_end)       bit_cnt <= bit_cnt + 10'd1;
            // A flush seen at any point during the fetch keeps the refilled line invalid.
            if (state == IDLE) flush_pend <= miss & flush_i;
            else if (flush_i)  flush_pend <= 1'b1;
            if (state == HOLD && state_nxt == GAP) line_valid <= ~(flush_pend | flush_i);
            else if (flush_i)                      line_valid <= 1'b0;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (miss) begin
            line_tag <= req_tag;
            tx_sr    <= {CMD_BYTE, req_tag};
        end else if (bit_end && (state == CMD || state == ADDR)) begin
            tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
        end
        if (state == DATA && phase_hi && div_cnt == '0)
            rx_sr <= {rx_sr[LINE_BITS-2:0], spi_miso_i};
    end

    // First received byte of each word lands in bits [7:0].
    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign line_words[w][8*b +: 8] = rx_sr[LINE_BITS-1-8*(4*w+b) -: 8];
        end
    end

    if (LINE_WORDS > 1) begin : g_sel
        assign rd_word = line_words[offset[OFS_W-1:2]];
    end else begin : g_sel1
        assign rd_word = line_words[0];
    end

    assign pready_o   = err | hit | (gap_first & rd_ok);
    assign pslverr_o  = err;
    assign prdata_o   = (hit | (gap_first & rd_ok)) ? rd_word : 32'h0;
    assign spi_nss_o  = (state == IDLE) || (state == GAP);
    assign spi_sck_o  = bit_state & phase_hi;
    assign spi_mosi_o = (state == CMD || state == ADDR) & tx_sr[TX_W-1];
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_apb4_spifs_xip.sv
// Bench for apb4_spifs_xip: unit 0 uses default parameters, unit 1 uses
// FAST_READ=1, ADDR_WIDTH=32, LINE_WORDS=1, CLK_DIV=1; each has a SPI flash model.
`timescale 1ns/1ps
module tb_apb4_spifs_xip;

    localparam int NU = 2;
    localparam logic [31:0] WIN = 32'h3000_0000;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic [31:0]   paddr  [NU];
    logic [31:0]   pwdata [NU];
    logic [31:0]   prdata [NU];
    logic [NU-1:0] pwrite, psel, penable, pready, pslverr, flush, sck, nss, mosi, busy;
    int            rises   [NU];
    int            fetches [NU];
    logic [7:0]    cap_cmd  [NU];
    logic [31:0]   cap_addr [NU];

    int tests = 0;
    int fails = 0;
    logic        mvalid;
    logic [31:0] mtag;

    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd29;
        return m ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] o;
        o = (a - WIN) & 32'hFFFF_FFFC;
        return {flash_byte(o + 32'd3), flash_byte(o + 32'd2), flash_byte(o + 32'd1), flash_byte(o)};
    endfunction

    function automatic int cfg_aw(input int u); return (u == 0) ? 24 : 32; endfunction
    function automatic int cfg_lw(input int u); return (u == 0) ? 4 : 1; endfunction
    function automatic int cfg_cd(input int u); return (u == 0) ? 2 : 1; endfunction
    function automatic int cfg_dm(input int u); return (u == 0) ? 0 : 8; endfunction

    function automatic int n_bits(input int u);
        return 8 + cfg_aw(u) + cfg_dm(u) + 32 * cfg_lw(u);
    endfunction

    function automatic int miss_lat(input int u);
        return 1 + (2 * n_bits(u) + 2) * cfg_cd(u);
    endfunction

    for (genvar g = 0; g < NU; g++) begin : unit
        localparam int AW  = (g == 0) ? 24 : 32;
        localparam int LW  = (g == 0) ? 4 : 1;
        localparam int CD  = (g == 0) ? 2 : 1;
        localparam bit FR  = (g != 0);
        localparam int HDR = 8 + AW + (FR ? 8 : 0);

        logic        miso  = 1'b0;
        logic        nss_q = 1'b1;
        logic        sck_q = 1'b0;
        int          cnt = 0;
        int          nrise = 0;
        int          nfetch = 0;
        logic [7:0]  cmd = '0;
        logic [31:0] addr = '0;

        apb4_spifs_xip #(
            .ADDR_WIDTH(AW), .LINE_WORDS(LW), .CLK_DIV(CD), .FAST_READ(FR),
            .WIN_START(32'h3000_0000), .WIN_END(32'h30FF_FFFF)
        ) dut (
            .pclk_i(pclk), .presetn_i(presetn),
            .paddr_i(paddr[g]), .pwrite_i(pwrite[g]), .psel_i(psel[g]), .penable_i(penable[g]),
            .pwdata_i(pwdata[g]), .prdata_o(prdata[g]), .pready_o(pready[g]), .pslverr_o(pslverr[g]),
            .flush_i(flush[g]), .spi_sck_o(sck[g]), .spi_nss_o(nss[g]), .spi_mosi_o(mosi[g]),
            .spi_miso_i(miso), .busy_o(busy[g])
        );

        // Mode-0 flash: capture command/address on rising SCK, shift data out on falling SCK.
        always @(nss[g] or sck[g]) begin
            if (nss[g] === 1'b0 && nss_q === 1'b1) begin
                cnt = 0;
                nfetch++;
                cmd = '0;
                addr = '0;
            end
            if (sck[g] === 1'b1 && sck_q === 1'b0) begin
                nrise++;
                if (cnt < 8) cmd = {cmd[6:0], mosi[g]};
                else if (cnt < 8 + AW) addr = {addr[30:0], mosi[g]};
                cnt++;
            end
            if (sck[g] === 1'b0 && sck_q === 1'b1) begin
                int idx;
                logic [7:0] byt;
                idx = cnt - HDR;
                if (idx >= 0) begin
                    byt = flash_byte(addr + 32'(idx / 8));
                    miso = byt[7 - (idx % 8)];
                end else begin
                    miso = 1'b0;
                end
            end
            nss_q = nss[g];
            sck_q = sck[g];
        end

        assign rises[g]    = nrise;
        assign fetches[g]  = nfetch;
        assign cap_cmd[g]  = cmd;
        assign cap_addr[g] = addr;
    end

    task automatic apb_read(input int u, input logic [31:0] a, input logic wr,
                            output logic [31:0] d, output int lat, output logic err);
        @(posedge pclk); #1;
        paddr[u] = a; pwrite[u] = wr; pwdata[u] = $urandom; psel[u] = 1'b1; penable[u] = 1'b0;
        @(posedge pclk); #1;
        penable[u] = 1'b1;
        lat = 0;
        @(negedge pclk);
        while (pready[u] !== 1'b1 && lat < 2000) begin
            @(negedge pclk);
            lat++;
        end
        d = prdata[u];
        err = pslverr[u];
        if (pready[u] !== 1'b1) lat = -1;
        @(posedge pclk); #1;
        psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
    endtask

    task automatic pulse_flush(input int u);
        @(posedge pclk); #1 flush[u] = 1'b1;
        @(posedge pclk); #1 flush[u] = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < NU; i++) begin
            tests++;
            if ({nss[i], sck[i], mosi[i], pready[i], pslverr[i], busy[i]} !== 6'b100000) begin
                fails++;
                $display("FAIL reset_ctrl u%0d: got nss/sck/mosi/rdy/err/busy=%b want 100000", i,
                         {nss[i], sck[i], mosi[i], pready[i], pslverr[i], busy[i]});
            end
            tests++;
            if (prdata[i] !== 32'h0) begin
                fails++;
                $display("FAIL reset_prdata u%0d: got %h want 0", i, prdata[i]);
            end
        end
        @(posedge pclk); #1 presetn = 1'b1;
    endtask

    task automatic test_miss();
        logic [31:0] d; int lat; logic err; int r0;
        r0 = rises[0];
        apb_read(0, 32'h3000_0104, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(0)) begin fails++; $display("FAIL miss_latency: got %0d want %0d", lat, miss_lat(0)); end
        tests++;
        if (d !== exp_word(32'h3000_0104) || err !== 1'b0) begin
            fails++; $display("FAIL miss_data: got %h err=%b want %h err=0", d, err, exp_word(32'h3000_0104));
        end
        tests++;
        if (cap_cmd[0] !== 8'h03 || cap_addr[0] !== 32'h0000_0100) begin
            fails++; $display("FAIL miss_cmd_addr: got %h/%h want 03/00000100", cap_cmd[0], cap_addr[0]);
        end
        tests++;
        if (rises[0] - r0 != n_bits(0)) begin
            fails++; $display("FAIL miss_sck_count: got %0d want %0d", rises[0] - r0, n_bits(0));
        end
    endtask

    task automatic test_hit();
        logic [31:0] d; int lat; logic err; int r0;
        r0 = rises[0];
        apb_read(0, 32'h3000_0108, 1'b0, d, lat, err);
        tests++;
        if (lat != 0 || err !== 1'b0) begin fails++; $display("FAIL hit_latency: got %0d err=%b want 0 err=0", lat, err); end
        tests++;
        if (d !== exp_word(32'h3000_0108)) begin fails++; $display("FAIL hit_data: got %h want %h", d, exp_word(32'h3000_0108)); end
        tests++;
        if (rises[0] != r0) begin fails++; $display("FAIL hit_no_sck: got %0d edges want 0", rises[0] - r0); end
    endtask

    task automatic test_error();
        logic [31:0] d; int lat; logic err; int f0;
        f0 = fetches[0];
        apb_read(0, 32'h3000_0000, 1'b1, d, lat, err);
        tests++;
        if (lat != 0 || err !== 1'b1 || d !== 32'h0) begin
            fails++; $display("FAIL err_write: got lat=%0d err=%b d=%h want 0/1/0", lat, err, d);
        end
        apb_read(0, 32'h4000_0000, 1'b0, d, lat, err);
        tests++;
        if (lat != 0 || err !== 1'b1 || d !== 32'h0) begin
            fails++; $display("FAIL err_window: got lat=%0d err=%b d=%h want 0/1/0", lat, err, d);
        end
        tests++;
        if (fetches[0] != f0) begin fails++; $display("FAIL err_no_spi: got %0d fetches want 0", fetches[0] - f0); end
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat; logic err;
        pulse_flush(0);
        apb_read(0, 32'h3000_0104, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(0) || d !== exp_word(32'h3000_0104)) begin
            fails++; $display("FAIL flush_refetch: got lat=%0d d=%h want %0d/%h", lat, d, miss_lat(0), exp_word(32'h3000_0104));
        end
        fork
            apb_read(0, 32'h3000_0204, 1'b0, d, lat, err);
            begin
                repeat (100) @(posedge pclk);
                #1 flush[0] = 1'b1;
                @(posedge pclk); #1 flush[0] = 1'b0;
            end
        join
        tests++;
        if (lat != miss_lat(0) || d !== exp_word(32'h3000_0204)) begin
            fails++; $display("FAIL flush_mid_answer: got lat=%0d d=%h want %0d/%h", lat, d, miss_lat(0), exp_word(32'h3000_0204));
        end
        apb_read(0, 32'h3000_0208, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(0) || d !== exp_word(32'h3000_0208)) begin
            fails++; $display("FAIL flush_mid_invalid: got lat=%0d d=%h want %0d/%h", lat, d, miss_lat(0), exp_word(32'h3000_0208));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; int lat; logic err;
        @(posedge pclk); #1;
        paddr[0] = 32'h3000_0204; pwrite[0] = 1'b0; psel[0] = 1'b1; penable[0] = 1'b0;
        @(posedge pclk); #1;
        penable[0] = 1'b1; flush[0] = 1'b1;
        @(negedge pclk);
        tests++;
        if (pready[0] !== 1'b1 || pslverr[0] !== 1'b0 || prdata[0] !== exp_word(32'h3000_0204)) begin
            fails++; $display("FAIL flush_hit_served: got rdy=%b err=%b d=%h want 1/0/%h",
                              pready[0], pslverr[0], prdata[0], exp_word(32'h3000_0204));
        end
        @(posedge pclk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0; flush[0] = 1'b0;
        apb_read(0, 32'h3000_0204, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(0)) begin fails++; $display("FAIL flush_hit_cleared: got lat=%0d want %0d", lat, miss_lat(0)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, line; int lat; logic err, wr; int r0, kind; logic want_hit;
        pulse_flush(0);
        mvalid = 1'b0;
        mtag = '0;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                pulse_flush(0);
                mvalid = 1'b0;
            end else if (kind <= 2) begin
                wr = (kind == 1);
                a = wr ? (WIN + ($urandom & 32'h00FF_FFFC))
                       : ($urandom_range(0, 1) ? 32'h3100_0000 : 32'h2FFF_FFFC);
                r0 = rises[0];
                apb_read(0, a, wr, d, lat, err);
                tests++;
                if (lat != 0 || err !== 1'b1 || d !== 32'h0 || rises[0] != r0) begin
                    fails++; $display("FAIL rand_err a=%h wr=%b: got lat=%0d err=%b d=%h want 0/1/0", a, wr, lat, err, d);
                end
            end else begin
                if (kind == 3) a = 32'h30FF_FFFC;
                else a = WIN + 32'h1000 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
                line = (a - WIN) & 32'hFFFF_FFF0;
                want_hit = mvalid && (mtag == line);
                r0 = rises[0];
                apb_read(0, a, 1'b0, d, lat, err);
                tests++;
                if (lat != (want_hit ? 0 : miss_lat(0)) || err !== 1'b0) begin
                    fails++; $display("FAIL rand_latency a=%h: got %0d err=%b want %0d err=0", a, lat, err, want_hit ? 0 : miss_lat(0));
                end
                tests++;
                if (d !== exp_word(a)) begin fails++; $display("FAIL rand_data a=%h: got %h want %h", a, d, exp_word(a)); end
                tests++;
                if (rises[0] - r0 != (want_hit ? 0 : n_bits(0))) begin
                    fails++; $display("FAIL rand_sck a=%h: got %0d want %0d", a, rises[0] - r0, want_hit ? 0 : n_bits(0));
                end
                mvalid = 1'b1;
                mtag = line;
            end
        end
    endtask

    task automatic test_fast_read();
        logic [31:0] d; int lat; logic err; int r0;
        r0 = rises[1];
        apb_read(1, 32'h3000_0010, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(1)) begin fails++; $display("FAIL fast_latency: got %0d want %0d", lat, miss_lat(1)); end
        tests++;
        if (d !== exp_word(32'h3000_0010) || err !== 1'b0) begin
            fails++; $display("FAIL fast_data: got %h err=%b want %h", d, err, exp_word(32'h3000_0010));
        end
        tests++;
        if (cap_cmd[1] !== 8'h0B || cap_addr[1] !== 32'h0000_0010) begin
            fails++; $display("FAIL fast_cmd_addr: got %h/%h want 0b/00000010", cap_cmd[1], cap_addr[1]);
        end
        tests++;
        if (rises[1] - r0 != n_bits(1)) begin fails++; $display("FAIL fast_sck_count: got %0d want %0d", rises[1] - r0, n_bits(1)); end
        apb_read(1, 32'h3000_0010, 1'b0, d, lat, err);
        tests++;
        if (lat != 0 || d !== exp_word(32'h3000_0010)) begin
            fails++; $display("FAIL fast_hit: got lat=%0d d=%h want 0/%h", lat, d, exp_word(32'h3000_0010));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat; logic err; int r0, n;
        pulse_flush(0);
        r0 = rises[0];
        @(posedge pclk); #1;
        paddr[0] = 32'h3000_0304; pwrite[0] = 1'b0; psel[0] = 1'b1; penable[0] = 1'b0;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!((rises[0] - r0 >= 40) && sck[0] === 1'b1) && n < 2000);
        tests++;
        if (n >= 2000) begin fails++; $display("FAIL rstmid_reach_data: got timeout want DATA phase"); end
        presetn = 1'b0;
        #1;
        tests++;
        if ({nss[0], sck[0], busy[0], pready[0]} !== 4'b1000) begin
            fails++; $display("FAIL rstmid_outputs: got nss/sck/busy/rdy=%b want 1000", {nss[0], sck[0], busy[0], pready[0]});
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        r0 = rises[0];
        apb_read(0, 32'h3000_0304, 1'b0, d, lat, err);
        tests++;
        if (lat != miss_lat(0) || d !== exp_word(32'h3000_0304) || rises[0] - r0 != n_bits(0)) begin
            fails++; $display("FAIL rstmid_refetch: got lat=%0d d=%h edges=%0d want %0d/%h/%0d",
                              lat, d, rises[0] - r0, miss_lat(0), exp_word(32'h3000_0304), n_bits(0));
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: got no finish want finish before 800us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NU; i++) begin
            paddr[i] = '0; pwdata[i] = '0;
            pwrite[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0; flush[i] = 1'b0;
        end
        mvalid = 1'b0;
        mtag = '0;
        test_reset();
        test_miss();
        test_hit();
        test_error();
        test_flush();
        test_back_to_back();
        test_random();
        test_fast_read();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
